// File: rtl/tx_frame_buffer.sv
// Store-and-forward transmit frame buffer: holds each frame until its tlast word
// arrives, then bursts it to the MAC TX stage; frames larger than the buffer are dropped.
module tx_frame_buffer #(
  parameter int DATA_WIDTH = 73,
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_pipe_write_data,
  input  logic                  in_pipe_write_req,
  output logic                  in_pipe_write_ack,
  output logic [DATA_WIDTH-1:0] out_pipe_write_data,
  output logic                  out_pipe_write_req,
  input  logic                  out_pipe_write_ack,
  output logic [DEPTH_LOG2:0]   frame_count,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [CNT_WIDTH-1:0]  frames_dropped,
  output logic                  drop_pulse
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {STORE, DROP} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                state;
  logic                  run;
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr, sent_ptr;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] q0, q1;
  logic [1:0]            out_cnt;

  logic [PW-1:0] used, readable;
  logic full, out_empty, drop_cond;
  logic in_acc, in_last, wr_en, commit;
  logic pop, pop_last, rd_en;

  // used counts every word not yet handed downstream, including prefetched ones
  assign used      = wr_ptr - sent_ptr;
  assign readable  = commit_ptr - rd_ptr;
  assign full      = (used == FULL_LVL);
  assign out_empty = (out_cnt == 2'd0) && !vld_p1;
  assign drop_cond = (state == STORE) && full && (readable == '0) && out_empty;

  // drop_cond keeps ack high on the cycle the oversize frame is recognised
  assign in_pipe_write_ack = run && ((state == DROP) || !full || drop_cond);
  assign in_acc  = in_pipe_write_req && in_pipe_write_ack;
  assign in_last = in_pipe_write_data[DATA_WIDTH-1];
  assign wr_en   = in_acc && (state == STORE) && !drop_cond;
  assign commit  = wr_en && in_last;

  assign out_pipe_write_req  = (out_cnt != 2'd0);
  assign out_pipe_write_data = q0;
  assign pop      = out_pipe_write_req && out_pipe_write_ack;
  assign pop_last = pop && q0[DATA_WIDTH-1];
  assign rd_en    = run && (readable != '0) &&
                    ((out_cnt + 2'(vld_p1)) <= (2'(pop) + 2'd1));

  // Deassertion synchroniser: logic starts running one edge after release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run <= 1'b0;
    else         run <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= in_pipe_write_data;
  end

  // Stage p1: synchronous memory read
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_p1 <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= STORE;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      rd_ptr         <= '0;
      sent_ptr       <= '0;
      vld_p1         <= 1'b0;
      out_cnt        <= 2'd0;
      q0             <= '0;
      q1             <= '0;
      frame_count    <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
      drop_pulse     <= 1'b0;
    end else if (run) begin
      drop_pulse <= 1'b0;
      if (wr_en)  wr_ptr     <= wr_ptr + PW'(1);
      if (commit) commit_ptr <= wr_ptr + PW'(1);

      case (state)
        STORE: if (drop_cond) begin
          wr_ptr <= commit_ptr;
          if (in_acc && in_last) begin
            drop_pulse     <= 1'b1;
            frames_dropped <= sat_inc(frames_dropped);
          end else begin
            state <= DROP;
          end
        end
        DROP: if (in_acc && in_last) begin
          drop_pulse     <= 1'b1;
          frames_dropped <= sat_inc(frames_dropped);
          state          <= STORE;
        end
        default: state <= STORE;
      endcase

      if (rd_en) rd_ptr   <= rd_ptr + PW'(1);
      if (pop)   sent_ptr <= sent_ptr + PW'(1);
      vld_p1 <= rd_en;

      if (commit && !pop_last)      frame_count <= frame_count + PW'(1);
      else if (!commit && pop_last) frame_count <= frame_count - PW'(1);
      if (pop_last) frames_sent <= sat_inc(frames_sent);

      // Stage p2: two-entry output queue, q0 is the head
      case ({vld_p1, pop})
        2'b10: begin
          if (out_cnt == 2'd0) q0 <= rd_data_p1;
          else                 q1 <= rd_data_p1;
          out_cnt <= out_cnt + 2'd1;
        end
        2'b01: begin
          q0      <= q1;
          out_cnt <= out_cnt - 2'd1;
        end
        2'b11: begin
          if (out_cnt == 2'd1) begin
            q0 <= rd_data_p1;
          end else begin
            q0 <= q1;
            q1 <= rd_data_p1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Directed bench for tx_frame_buffer (16-word buffer) with a scoreboard queue of
// words expected at the output, compared as they are transferred.
module tb_tx_frame_buffer;
  localparam int DW = 73;
  localparam int DL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_req = 1'b0;
  logic          in_ack;
  logic [DW-1:0] out_data;
  logic          out_req;
  logic          out_ack = 1'b1;
  logic [DL:0]   frame_count;
  logic [CW-1:0] frames_sent;
  logic [CW-1:0] frames_dropped;
  logic          drop_pulse;

  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  bit stalled = 0;
  bit send_done = 0;
  int cyc = 0;

  tx_frame_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .in_pipe_write_data  (in_data),
    .in_pipe_write_req   (in_req),
    .in_pipe_write_ack   (in_ack),
    .out_pipe_write_data (out_data),
    .out_pipe_write_req  (out_req),
    .out_pipe_write_ack  (out_ack),
    .frame_count         (frame_count),
    .frames_sent         (frames_sent),
    .frames_dropped      (frames_dropped),
    .drop_pulse          (drop_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (resetn && drop_pulse) pulse_cnt++;
  end

  always @(negedge clk) begin
    logic [DW-1:0] w;
    if (resetn && out_req && out_ack) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out got=%0h exp=none", out_data);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        total++;
        assert (out_data === w) else begin
          bad++;
          $error("FAIL out_data got=%0h exp=%0h", out_data, w);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input bit last);
    return {last, $urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic put_word(input logic [DW-1:0] w, input bit keep);
    int waitc = 0;
    in_req = 1'b1;
    in_data = w;
    forever begin
      @(negedge clk);
      if (in_ack) break;
      stalled = 1'b1;
      waitc++;
      if (waitc > 2000) begin
        chk("in_ack_timeout", 1'b0, 1'b1);
        break;
      end
    end
    if (keep) exp_q.push_back(w);
    @(posedge clk);
    #1;
    in_req = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit keep);
    for (int i = 0; i < n; i++) put_word(mk(i == n - 1), keep);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(exp_q.size() == 0 && !out_req) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", DW'(exp_q.size()), '0);
  endtask

  initial begin
    // reset state
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", out_req, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_fc", frame_count, '0);
    chk("rst_sent", frames_sent, '0);
    chk("rst_drop", frames_dropped, '0);
    chk("rst_pulse", drop_pulse, 1'b0);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_after_reset", in_ack, 1'b1);

    // single 8-word frame, latency and burst shape
    send_frame(8, 1);
    chk("t1_fc_commit", frame_count, 5'd1);
    chk("t1_req_n0", out_req, 1'b0);
    @(posedge clk); #1;
    chk("t1_req_n1", out_req, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      chk("t1_burst_req", out_req, 1'b1);
      @(posedge clk); #1;
    end
    chk("t1_req_end", out_req, 1'b0);
    chk("t1_fc_end", frame_count, '0);
    chk("t1_sent", frames_sent, 16'd1);
    chk("t1_q_empty", DW'(exp_q.size()), '0);

    // store-and-forward hold
    for (int i = 0; i < 5; i++) put_word(mk(1'b0), 1);
    for (int i = 0; i < 20; i++) begin
      chk("t2_hold_req", out_req, 1'b0);
      @(posedge clk); #1;
    end
    put_word(mk(1'b1), 1);
    wait_drain();
    chk("t2_sent", frames_sent, 16'd2);

    // backpressure with pseudo-random out ack
    fork
      begin
        send_frame(4, 1);
        send_frame(7, 1);
        send_frame(1, 1);
        send_done = 1'b1;
      end
      begin
        cyc = 0;
        while (!(send_done && exp_q.size() == 0) && cyc < 3000) begin
          @(posedge clk); #1;
          out_ack = 1'($urandom_range(0, 1));
          cyc++;
        end
      end
    join
    out_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_budget", DW'(cyc >= 3000), '0);
    chk("t3_sent", frames_sent, 16'd5);
    chk("t3_fc", frame_count, '0);

    // oversize frame is dropped whole
    stalled = 1'b0;
    pulse_cnt = 0;
    send_frame(20, 0);
    chk("t4_pulse_now", drop_pulse, 1'b1);
    chk("t4_no_stall", stalled, 1'b0);
    chk("t4_dropped", frames_dropped, 16'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_pulse_cnt", DW'(pulse_cnt), DW'(1));
    chk("t4_no_out", out_req, 1'b0);
    chk("t4_fc", frame_count, '0);
    send_frame(3, 1);
    wait_drain();
    chk("t4_sent", frames_sent, 16'd6);

    // full stall while frame 1 is held back
    out_ack = 1'b0;
    stalled = 1'b0;
    send_frame(10, 1);
    for (int i = 0; i < 6; i++) put_word(mk(1'b0), 1);
    chk("t5_no_early_stall", stalled, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_ack_low", in_ack, 1'b0);
      @(posedge clk); #1;
    end
    chk("t5_fc_held", frame_count, 5'd1);
    out_ack = 1'b1;
    for (int i = 0; i < 4; i++) put_word(mk(i == 3), 1);
    wait_drain();
    chk("t5_sent", frames_sent, 16'd8);
    chk("t5_fc", frame_count, '0);

    // asynchronous reset while a frame is streaming out
    send_frame(8, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_streaming", out_req, 1'b1);
    #1 resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_req", out_req, 1'b0);
    chk("t6_data", out_data, '0);
    chk("t6_fc", frame_count, '0);
    chk("t6_sent", frames_sent, '0);
    chk("t6_drop", frames_dropped, '0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    chk("t6_ack", in_ack, 1'b1);
    send_frame(2, 1);
    wait_drain();
    chk("t6_sent_after", frames_sent, 16'd1);
    chk("t6_fc_after", frame_count, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
